// File: rtl/step_sequencer_ctrl.sv
// Beat step sequencer: 8x16 pattern grid, tempo-driven playhead with per-step
// trigger pulses, handshaked pattern edits and a frame-latched cursor/button view.
module step_sequencer_ctrl #(
    parameter int STEPS          = 16,
    parameter int TRACKS         = 8,
    parameter int TICKS_PER_STEP = 6_250_000,
    parameter int X_ORIGIN       = 40,
    parameter int STEP_PX        = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              edit_valid,
    input  logic [3:0]        edit_step,
    input  logic [2:0]        edit_track,
    output logic              edit_ready,
    input  logic              frame_sync,
    output logic              running,
    output logic [3:0]        step_idx,
    output logic              step_tick,
    output logic [TRACKS-1:0] trig,
    output logic [9:0]        cursor_x,
    output logic [TRACKS-1:0] button,
    output logic [1:0]        dbg_state
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int TW = $clog2(TICKS_PER_STEP);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
    localparam logic [3:0]    STEP_LAST = 4'(STEPS - 1);
    localparam logic [SW-1:0] CLR_LAST  = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ret_run;
    logic [SW-1:0]     r_clr_idx;
    logic [TW-1:0]     r_tick;
    logic [3:0]        r_step;
    logic [TRACKS-1:0] r_grid [STEPS];

    logic              w_enter;
    logic              w_run_adv;
    logic              w_edit;
    logic [3:0]        w_step_nxt;
    logic [9:0]        w_cursor;

    // Handshake: an edit transfers on any edge where edit_valid && edit_ready.
    assign edit_ready = (r_state != S_CLEAR);
    assign running    = (r_state == S_RUN);
    assign step_idx   = r_step;
    assign dbg_state  = r_state;

    assign w_run_adv  = (r_state == S_RUN) && !clear && !stop;
    assign w_step_nxt = (r_step == STEP_LAST) ? 4'd0 : r_step + 4'd1;
    assign w_edit     = edit_valid && edit_ready
                        && ({1'b0, edit_step} < 5'(STEPS))
                        && ({1'b0, edit_track} < 4'(TRACKS));
    assign w_cursor   = 10'(X_ORIGIN + STEP_PX * int'(r_step));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_next = S_CLEAR;
                end else if (start && !stop) begin
                    w_next  = S_RUN;
                    w_enter = 1'b1;
                end
            end
            S_RUN: begin
                if (clear) begin
                    w_next = S_CLEAR;
                end else if (stop) begin
                    w_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (r_clr_idx == CLR_LAST) begin
                    w_next = r_ret_run ? S_RUN : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ret_run <= 1'b0;
            r_clr_idx <= '0;
            r_tick    <= '0;
            r_step    <= 4'd0;
            step_tick <= 1'b0;
            trig      <= '0;
            cursor_x  <= 10'(X_ORIGIN);
            button    <= '0;
            for (int i = 0; i < STEPS; i++) begin
                r_grid[i] <= '0;
            end
        end else begin
            step_tick <= 1'b0;
            trig      <= '0;

            if (w_enter) begin
                r_step    <= 4'd0;
                r_tick    <= '0;
                step_tick <= 1'b1;
                trig      <= r_grid[0];
            end else if ((r_state == S_RUN) && stop && !clear) begin
                r_step <= 4'd0;
                r_tick <= '0;
            end else if (w_run_adv) begin
                if (r_tick == TICK_LAST) begin
                    r_tick    <= '0;
                    r_step    <= w_step_nxt;
                    step_tick <= 1'b1;
                    trig      <= r_grid[w_step_nxt[SW-1:0]];
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end

            // Playhead and tick phase stay frozen while the grid is wiped.
            if ((r_state != S_CLEAR) && clear) begin
                r_ret_run <= (r_state == S_RUN);
                r_clr_idx <= '0;
            end
            if (r_state == S_CLEAR) begin
                r_grid[r_clr_idx] <= '0;
                r_clr_idx         <= r_clr_idx + 1'b1;
            end

            if (w_edit) begin
                r_grid[edit_step[SW-1:0]][edit_track] <= ~r_grid[edit_step[SW-1:0]][edit_track];
            end

            if (frame_sync) begin
                cursor_x <= w_cursor;
                button   <= running ? r_grid[r_step[SW-1:0]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Bench for step_sequencer_ctrl: directed play/edit/clear/frame scenarios then
// random traffic, all compared each cycle against a timeline-based reference model.
module tb_step_sequencer_ctrl;

    localparam int STEPS = 16;
    localparam int TRK   = 8;
    localparam int T     = 4;
    localparam int X0    = 40;
    localparam int PX    = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CLEAR = 2;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           clear = 1'b0;
    logic           edit_valid = 1'b0;
    logic [3:0]     edit_step = 4'd0;
    logic [2:0]     edit_track = 3'd0;
    logic           frame_sync = 1'b0;
    logic           edit_ready;
    logic           running;
    logic [3:0]     step_idx;
    logic           step_tick;
    logic [TRK-1:0] trig;
    logic [9:0]     cursor_x;
    logic [TRK-1:0] button;
    logic [1:0]     dbg_state;

    step_sequencer_ctrl #(
        .STEPS(STEPS), .TRACKS(TRK), .TICKS_PER_STEP(T), .X_ORIGIN(X0), .STEP_PX(PX)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .clear(clear),
        .edit_valid(edit_valid), .edit_step(edit_step), .edit_track(edit_track),
        .edit_ready(edit_ready), .frame_sync(frame_sync), .running(running),
        .step_idx(step_idx), .step_tick(step_tick), .trig(trig),
        .cursor_x(cursor_x), .button(button), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: playback position is derived from the number of
    // advancing RUN cycles since start (m_age), not from a tick counter.
    int             m_mode;
    int             m_ret;
    int             m_left;
    int             m_age;
    logic [TRK-1:0] m_grid [STEPS];
    logic           m_tick;
    logic [TRK-1:0] m_trig;
    int             m_cursor;
    logic [TRK-1:0] m_button;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int cur_step();
        if (m_mode == M_RUN || (m_mode == M_CLEAR && m_ret != 0))
            return (m_age / T) % STEPS;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ret = 0; m_left = 0; m_age = 0;
        m_tick = 1'b0; m_trig = '0; m_cursor = X0; m_button = '0;
        for (int i = 0; i < STEPS; i++) m_grid[i] = '0;
    endtask

    task automatic model_edge(input logic rst_n, input logic st, input logic sp,
                              input logic cl, input logic ev, input logic [3:0] es,
                              input logic [2:0] et, input logic fs);
        int  cur;
        logic rdy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cur = cur_step();
        rdy = (m_mode != M_CLEAR);
        if (fs) begin
            m_cursor = (X0 + cur * PX) % 1024;
            m_button = (m_mode == M_RUN) ? m_grid[cur] : '0;
        end
        m_tick = 1'b0;
        m_trig = '0;
        case (m_mode)
            M_IDLE: begin
                if (cl) begin
                    m_mode = M_CLEAR; m_ret = 0; m_left = STEPS;
                end else if (st && !sp) begin
                    m_mode = M_RUN; m_age = 0; m_tick = 1'b1; m_trig = m_grid[0];
                end
            end
            M_RUN: begin
                if (cl) begin
                    m_mode = M_CLEAR; m_ret = 1; m_left = STEPS;
                end else if (sp) begin
                    m_mode = M_IDLE;
                end else begin
                    m_age++;
                    if (m_age % T == 0) begin
                        m_tick = 1'b1;
                        m_trig = m_grid[(m_age / T) % STEPS];
                    end
                end
            end
            default: begin
                m_grid[STEPS - m_left] = '0;
                m_left--;
                if (m_left == 0) m_mode = (m_ret != 0) ? M_RUN : M_IDLE;
            end
        endcase
        if (ev && rdy) m_grid[es][et] = ~m_grid[es][et];
    endtask

    task automatic compare_all();
        check("running",    32'(running),    32'(m_mode == M_RUN));
        check("edit_ready", 32'(edit_ready), 32'(m_mode != M_CLEAR));
        check("step_idx",   32'(step_idx),   32'(cur_step()));
        check("step_tick",  32'(step_tick),  32'(m_tick));
        check("trig",       32'(trig),       32'(m_trig));
        check("cursor_x",   32'(cursor_x),   32'(m_cursor));
        check("button",     32'(button),     32'(m_button));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input logic rst_n, input logic st, input logic sp, input logic cl,
                       input logic ev, input logic [3:0] es, input logic [2:0] et,
                       input logic fs);
        Reset = rst_n; start = st; stop = sp; clear = cl;
        edit_valid = ev; edit_step = es; edit_track = et; frame_sync = fs;
        model_edge(rst_n, st, sp, cl, ev, es, et, fs);
        @(posedge Clk);
        #1;
        compare_all();
        start = 1'b0; stop = 1'b0; clear = 1'b0; edit_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 4'd0, 3'd0, 0);
    endtask

    task automatic edit(input logic [3:0] s, input logic [2:0] t);
        cyc(1, 0, 0, 0, 1, s, t, 0);
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0, 0, 4'd0, 3'd0, 0);
        cyc(0, 1, 0, 1, 1, 4'd3, 3'd1, 1);
        check("rst_cursor", 32'(cursor_x), 32'd40);
        check("rst_ready",  32'(edit_ready), 32'd1);

        // Idle: stop ignored, frame latch with playback off.
        cyc(1, 0, 1, 0, 0, 4'd0, 3'd0, 1);
        idle(2);

        // Edit/trigger pattern and play/wrap timing.
        edit(4'd3, 3'd2);
        edit(4'd3, 3'd7);
        cyc(1, 1, 0, 0, 0, 4'd0, 3'd0, 0);
        check("play_c1_tick", 32'(step_tick), 32'd1);
        check("play_c1_step", 32'(step_idx), 32'd0);
        idle(4);
        check("play_c5_tick", 32'(step_tick), 32'd1);
        check("play_c5_step", 32'(step_idx), 32'd1);
        idle(8);
        check("trig_s3", 32'(trig), 32'h84);
        edit(4'd3, 3'd2);
        idle(63);
        check("trig_s3_pass2", 32'(trig), 32'h80);
        idle(7);
        edit(4'd5, 3'd0);
        check("same_cyc_step", 32'(step_idx), 32'd5);
        check("same_cyc_trig", 32'(trig), 32'h00);
        idle(64);
        check("same_cyc_next", 32'(trig), 32'h01);

        // Clear during RUN at step 6, one tick into the step.
        idle(4);
        check("clr_at_s6", 32'(step_idx), 32'd6);
        idle(1);
        cyc(1, 0, 0, 1, 0, 4'd0, 3'd0, 0);
        check("clr_ready_lo", 32'(edit_ready), 32'd0);
        idle(15);
        check("clr_ready_end", 32'(edit_ready), 32'd0);
        idle(1);
        check("clr_ready_back", 32'(edit_ready), 32'd1);
        check("clr_resume_s6", 32'(step_idx), 32'd6);
        idle(3);
        check("clr_resume_tick", 32'(step_tick), 32'd1);
        check("clr_resume_s7", 32'(step_idx), 32'd7);
        idle(64);

        // Frame latch at step 4 with grid[4] = 8'h01.
        cyc(1, 0, 1, 0, 0, 4'd0, 3'd0, 0);
        edit(4'd4, 3'd0);
        cyc(1, 1, 0, 0, 0, 4'd0, 3'd0, 0);
        idle(16);
        cyc(1, 0, 0, 0, 0, 4'd0, 3'd0, 1);
        check("frame_cursor", 32'(cursor_x), 32'd168);
        check("frame_button", 32'(button), 32'h01);
        cyc(1, 0, 1, 0, 0, 4'd0, 3'd0, 0);
        cyc(1, 0, 0, 0, 0, 4'd0, 3'd0, 1);
        check("frame_stop_cursor", 32'(cursor_x), 32'd40);
        check("frame_stop_button", 32'(button), 32'h00);

        // start+stop together stays idle; reset during CLEAR.
        cyc(1, 1, 1, 0, 0, 4'd0, 3'd0, 0);
        check("startstop_idle", 32'(running), 32'd0);
        edit(4'd15, 3'd3);
        cyc(1, 0, 0, 1, 0, 4'd0, 3'd0, 0);
        idle(5);
        cyc(0, 1, 0, 1, 1, 4'd2, 3'd2, 1);
        check("rst_clr_ready", 32'(edit_ready), 32'd1);
        check("rst_clr_cursor", 32'(cursor_x), 32'd40);
        cyc(1, 1, 0, 0, 0, 4'd0, 3'd0, 0);
        idle(64);
        check("rst_grid_s0", 32'(trig), 32'h00);
        cyc(1, 0, 1, 0, 0, 4'd0, 3'd0, 0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 599) != 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 119) == 0),
                ($urandom_range(0, 2) == 0),
                4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/step_sequencer_ctrl.md
# step_sequencer_ctrl

Step sequencer controller for the beat-sequencer display and trigger path. It holds an 8-track × 16-step pattern grid and advances a playhead at a fixed tempo, emitting one-cycle trigger pulses per step. Pattern edits arrive through a valid/ready handshake. Once per video frame it latches the playhead position and active-step pattern (cursor_x, button) for the color mapper, so the image never changes mid-frame.

## Interface
- STEPS, 16: steps per pattern; power of two, max 16.
- TRACKS, 8: tracks per step; equals width of trig/button.
- TICKS_PER_STEP, 6_250_000: Clk cycles per step (0.125 s at 50 MHz); ≥ 2.
- X_ORIGIN, 40: pixel X of step 0 cursor.
- STEP_PX, 32: pixel pitch between steps.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  pulse; begin playback.
- stop  in  1  pulse; halt playback, rewind to step 0.
- clear  in  1  pulse; zero whole pattern grid.
- edit_valid  in  1  edit request.
- edit_step  in  4  step to edit.
- edit_track  in  3  track to edit.
- edit_ready  out  1  edit accepted when valid && ready.
- frame_sync  in  1  one-cycle pulse at start of vertical blank.
- running  out  1  high in RUN.
- step_idx  out  4  current playhead step.
- step_tick  out  1  one-cycle pulse on each step entry.
- trig  out  TRACKS  pattern of entered step, valid only with step_tick, else 0.
- cursor_x  out  10  frame-latched playhead pixel X.
- button  out  TRACKS  frame-latched pattern of playhead step (0 when not running).

## Operation
- FSM states: IDLE, RUN, CLEAR. Reset → IDLE. Reset clears grid, counters, and all outputs. cursor_x resets to X_ORIGIN; everything else resets to 0.
- IDLE: start → RUN. stop ignored. clear → CLEAR.
- RUN: stop → IDLE, with step_idx=0 and tick counter=0. clear → CLEAR (playback suspended). start ignored.
- start and stop in the same cycle: stop wins; no state change from IDLE.
- clear has priority over start/stop in the same cycle.
- CLEAR: writes zero to one step per cycle, step 0..STEPS-1. Exits after STEPS cycles to the state held before entry (IDLE or RUN). Tick counter and step_idx stay frozen; no step_tick. start/stop/clear ignored while in CLEAR.
- Edit: accepted when edit_valid && edit_ready. Toggles grid[edit_step][edit_track]. edit_ready = 1 except in CLEAR. edit_step ≥ STEPS is accepted and has no effect.
- Tick counter runs 0..TICKS_PER_STEP-1 in RUN only. At terminal count, step_idx increments, wrapping STEPS-1 → 0.
- Step entry occurs on the first RUN cycle after IDLE (step 0) and at each terminal count. On entry, step_tick=1 and trig=grid[new step].
- Edit and step entry to the same step in the same cycle: trig uses the pre-edit value; the toggle is visible from the next cycle.
- frame_sync: cursor_x ← (X_ORIGIN + step_idx·STEP_PX) mod 1024 and button ← running ? grid[step_idx] : 0. Both hold until the next frame_sync. frame_sync coinciding with step entry latches the old step_idx.

## Timing
- start accepted at edge N: running=1, step_tick=1, step_idx=0, and trig=grid[0] are all valid after edge N+1.
- Subsequent step_tick pulses occur every TICKS_PER_STEP cycles.
- stop at edge N: running=0, step_idx=0, step_tick=0 after edge N+1.
- Edit toggle is visible in grid one cycle after acceptance. Throughput is 1 edit/cycle.
- clear at edge N: edit_ready=0 for cycles N+1..N+STEPS, returning to 1 at N+STEPS+1.
- frame_sync: outputs update one cycle after the pulse. There is no combinational path from inputs to any output.
- Reset low mid-CLEAR or mid-RUN: all state and outputs take reset values on the next edge, regardless of other inputs.

## Test plan
- Play/wrap (TICKS_PER_STEP=4, STEPS=16): start → step_tick at cycles 1, 5, 9, …; step_idx 0..15 then 0 at cycle 65; running=1.
- Edit/trigger: toggle (3,2) and (3,7), then start → trig=8'h84 exactly on step 3's tick, 0 elsewhere. Toggle (3,2) again → next pass trig=8'h80.
- Same-cycle edit at step entry: toggle (5,0) on step 5's entry cycle → trig bit0 shows the old value; the following pass shows the new value.
- Clear during RUN at step 6: edit_ready=0 for 16 cycles, no step_tick. Resumes at step 6 with remaining ticks intact; all later trig=0.
- Frame latch: step_idx=4, grid[4]=8'h01, frame_sync → cursor_x=168, button=8'h01. After stop + frame_sync → cursor_x=40, button=0.
- Priority/reset: start+stop same cycle in IDLE → stays IDLE. Reset low during CLEAR → IDLE, edit_ready=1, grid zero, outputs at reset values.
